// File: rtl/main_ram_arbiter_pkg.sv
// ============================================================================
// main_ram_pkg : shared widths, FSM encoding and byte-mask helper for main_ram_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package main_ram_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int NUM_BYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [NUM_BYTES-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/main_ram_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin one-hot grant; pointer moves past the winner on advance
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] winner_o
);

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic [PW:0]   w_idx;
    logic          w_found;

    // Scan from the pointer upward, wrapping modulo N; first pending request wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!w_found && req_i[w_idx[PW-1:0]]) begin
                w_found                  = 1'b1;
                grant_o[w_idx[PW-1:0]]   = 1'b1;
                winner_o                 = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = (winner_o == PW'(N-1)) ? '0 : winner_o + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/main_ram_arbiter.sv
// ============================================================================
// main_ram_arbiter : round-robin sharing of the single-port work RAM, RMW for sub-word writes
// Revision         : 1.0
// ============================================================================
`default_nettype none

module main_ram_arbiter
    import main_ram_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*NUM_BYTES-1:0]  req_be_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic [ADDR_W-1:0]             ram_address_o,
    output logic                          ram_wren_o,
    output logic [DATA_W-1:0]             ram_data_o,
    input  logic [DATA_W-1:0]             ram_q_i,
    output logic                          busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    merge_q, merge_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]    ram_addr_last_q;
    logic [DATA_W-1:0]    ram_data_last_q;

    logic [NUM_BYTES-1:0] w_be_a    [NUM_REQ];
    logic [ADDR_W-1:0]    w_addr_a  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata_a [NUM_REQ];

    logic [NUM_REQ-1:0]   w_grant;
    logic [PW-1:0]        w_winner;
    logic                 w_accept;
    logic                 w_we;
    logic [NUM_BYTES-1:0] w_be;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [DATA_W-1:0]    w_mask;
    logic                 w_full_wr;
    logic                 w_partial;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_be_a[i]    = req_be_i[i*NUM_BYTES +: NUM_BYTES];
        assign w_addr_a[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
        assign w_wdata_a[i] = req_wdata_i[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .req_i     (req_valid_i),
        .advance_i (w_accept),
        .grant_o   (w_grant),
        .winner_o  (w_winner)
    );

    assign w_accept  = (state_q == IDLE) && (|w_grant);
    assign w_we      = req_we_i[w_winner];
    assign w_be      = w_be_a[w_winner];
    assign w_addr    = w_addr_a[w_winner];
    assign w_wdata   = w_wdata_a[w_winner];
    assign w_mask    = be_to_mask(w_be);
    assign w_full_wr = w_we && (&w_be);
    assign w_partial = w_we && (|w_be) && !(&w_be);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept && w_partial) state_d = RMW;
            RMW:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port holds its last address/data whenever nothing is driven onto it.
    always_comb begin
        req_ready_o   = '0;
        ram_wren_o    = 1'b0;
        ram_address_o = ram_addr_last_q;
        ram_data_o    = ram_data_last_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    req_ready_o   = w_grant;
                    ram_address_o = w_addr;
                    if (w_full_wr) begin
                        ram_wren_o = 1'b1;
                        ram_data_o = w_wdata;
                    end
                end
            end
            RMW: begin
                ram_address_o = addr_q;
                ram_data_o    = merge_q;
                ram_wren_o    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        addr_d      = addr_q;
        merge_d     = merge_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == RMW) begin
            rsp_valid_d[owner_q] = 1'b1;
        end else if (w_accept) begin
            if (!w_we) begin
                rsp_rdata_d = ram_q_i;
            end
            if (w_partial) begin
                owner_d = w_winner;
                addr_d  = w_addr;
                merge_d = (ram_q_i & ~w_mask) | (w_wdata & w_mask);
            end else begin
                rsp_valid_d[w_winner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            owner_q         <= '0;
            addr_q          <= '0;
            merge_q         <= '0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            ram_addr_last_q <= '0;
            ram_data_last_q <= '0;
        end else begin
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            merge_q         <= merge_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            ram_addr_last_q <= ram_address_o;
            ram_data_last_q <= ram_data_o;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign busy_o      = (state_q == RMW) || (|rsp_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
// ============================================================================
// tb_main_ram_arbiter : directed stimulus with a response scoreboard and a RAM model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_main_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  v;
    logic [2:0]  we_v;
    logic [3:0]  be_a  [3];
    logic [13:0] ad_a  [3];
    logic [31:0] wd_a  [3];
    logic [11:0] req_be;
    logic [41:0] req_addr;
    logic [95:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [13:0] ram_address;
    logic        ram_wren;
    logic [31:0] ram_data;
    logic [31:0] ram_q;
    logic        busy;

    logic [31:0] mem [16384];

    typedef struct {
        int          idx;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          exp_g [6];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    always_comb begin
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            req_be[i*4 +: 4]     = be_a[i];
            req_addr[i*14 +: 14] = ad_a[i];
            req_wdata[i*32 +: 32] = wd_a[i];
        end
    end

    assign ram_q = mem[ram_address];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
    end

    main_ram_arbiter #(.NUM_REQ(3)) dut (
        .clock_i       (clk),
        .reset_n_i     (rst_n),
        .req_valid_i   (v),
        .req_ready_o   (req_ready),
        .req_we_i      (we_v),
        .req_be_i      (req_be),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .ram_address_o (ram_address),
        .ram_wren_o    (ram_wren),
        .ram_data_o    (ram_data),
        .ram_q_i       (ram_q),
        .busy_o        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input bit rd, input logic [31:0] d);
        exp_t e;
        e.idx  = r;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_rd = '0;
        end else if (rsp_valid != 3'b000) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.idx);
                if (e.rd) begin
                    chk("rsp_rdata", rsp_rdata, e.data);
                    last_rd = e.data;
                end else begin
                    chk("rsp_rdata_hold", rsp_rdata, last_rd);
                end
            end
        end
    end

    task automatic single(input int r, input bit w, input logic [3:0] b, input logic [13:0] a,
                          input logic [31:0] d, input logic [31:0] erd);
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        push(r, !w, erd);
        v[r] = 1'b1; we_v[r] = w; be_a[r] = b; ad_a[r] = a; wd_a[r] = d;
        @(negedge clk);
        while (!req_ready[r] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("grant", 32'(req_ready), 32'(1) << r);
        chk("accept_addr", 32'(ram_address), 32'(a));
        chk("accept_wren", 32'(ram_wren), (w && b == 4'hF) ? 32'd1 : 32'd0);
        if (w && b == 4'hF) chk("accept_wdata", ram_data, d);
        @(posedge clk);
        #1;
        v[r] = 1'b0;
    endtask

    task automatic expect_rsp(input int r);
        @(negedge clk);
        chk("rsp_latency", 32'(rsp_valid), 32'(1) << r);
    endtask

    task automatic rmw_chk(input logic [13:0] a, input logic [31:0] m);
        @(negedge clk);
        chk("rmw_ready", 32'(req_ready), 32'h0);
        chk("rmw_wren", 32'(ram_wren), 32'h1);
        chk("rmw_addr", 32'(ram_address), 32'(a));
        chk("rmw_data", ram_data, m);
        chk("rmw_busy", 32'(busy), 32'h1);
    endtask

    task automatic run_grants(input int n, input bit keep);
        int got;
        int cyc;
        for (int g = 0; g < n; g++) begin
            got = -1;
            cyc = 0;
            while (got < 0 && cyc < 10) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) if (req_ready[i]) got = i;
                cyc++;
            end
            chk("grant_order", 32'(got), 32'(exp_g[g]));
            @(posedge clk);
            #1;
            if (!keep && got >= 0) v[got] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        v = '0; we_v = '0;
        for (int i = 0; i < 3; i++) begin
            be_a[i] = '0; ad_a[i] = '0; wd_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_wren", 32'(ram_wren), 32'h0);
        chk("rst_address", 32'(ram_address), 32'h0);
        chk("rst_data", ram_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_wren || rsp_valid != 3'b000) cnt++;
        end
        chk("idle_quiet", 32'(cnt), 32'h0);

        // Full write, read back, then a byte-1 partial write and read back.
        single(1, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF, 32'h0);
        expect_rsp(1);
        single(0, 1'b0, 4'h0, 14'h0010, 32'h0, 32'hDEADBEEF);
        expect_rsp(0);
        single(0, 1'b1, 4'b0010, 14'h0010, 32'h0000AA00, 32'h0);
        rmw_chk(14'h0010, 32'hDEADAAEF);
        expect_rsp(0);
        single(2, 1'b0, 4'h0, 14'h0010, 32'h0, 32'hDEADAAEF);
        expect_rsp(2);

        single(1, 1'b1, 4'hF, 14'h0020, 32'h11111111, 32'h0);
        expect_rsp(1);
        single(1, 1'b1, 4'hF, 14'h0021, 32'h22222222, 32'h0);
        expect_rsp(1);
        single(1, 1'b1, 4'hF, 14'h0022, 32'h33333333, 32'h0);
        expect_rsp(1);
        single(1, 1'b1, 4'hF, 14'h0030, 32'h12345678, 32'h0);
        expect_rsp(1);
        single(1, 1'b1, 4'h0, 14'h0020, 32'hFFFFFFFF, 32'h0);
        expect_rsp(1);
        single(2, 1'b1, 4'hF, 14'h3FFF, 32'hCAFEF00D, 32'h0);
        expect_rsp(2);

        // All three reading continuously; pointer starts at 0.
        @(posedge clk);
        #1;
        we_v = 3'b000;
        ad_a[0] = 14'h0020; ad_a[1] = 14'h0021; ad_a[2] = 14'h0022;
        v = 3'b111;
        for (int k = 0; k < 2; k++) begin
            push(0, 1'b1, 32'h11111111);
            push(1, 1'b1, 32'h22222222);
            push(2, 1'b1, 32'h33333333);
        end
        exp_g = '{0, 1, 2, 0, 1, 2};
        run_grants(6, 1'b1);
        v = 3'b000;
        repeat (3) @(negedge clk);

        // Partial write by 2 while 0 and 1 wait; pointer set to 2 first.
        single(1, 1'b0, 4'h0, 14'h0021, 32'h0, 32'h22222222);
        expect_rsp(1);
        @(posedge clk);
        #1;
        we_v = 3'b100;
        be_a[2] = 4'b0100; ad_a[2] = 14'h0030; wd_a[2] = 32'h00CC0000;
        ad_a[0] = 14'h0030; ad_a[1] = 14'h0021;
        push(2, 1'b0, 32'h0);
        push(0, 1'b1, 32'h12CC5678);
        push(1, 1'b1, 32'h22222222);
        v = 3'b111;
        @(negedge clk);
        chk("rmw_accept_ready", 32'(req_ready), 32'h4);
        chk("rmw_accept_wren", 32'(ram_wren), 32'h0);
        @(posedge clk);
        #1;
        v[2] = 1'b0;
        rmw_chk(14'h0030, 32'h12CC5678);
        exp_g[0] = 0;
        exp_g[1] = 1;
        run_grants(2, 1'b0);
        repeat (3) @(negedge clk);

        // Reset while the RMW write is pending.
        @(posedge clk);
        #1;
        we_v = 3'b100;
        be_a[2] = 4'b0001; ad_a[2] = 14'h3FFF; wd_a[2] = 32'h000000AA;
        v = 3'b100;
        @(negedge clk);
        chk("abort_accept_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        v = 3'b000;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wren", 32'(ram_wren), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != 3'b000) cnt++;
        end
        chk("abort_no_rsp", 32'(cnt), 32'h0);

        @(posedge clk);
        #1;
        we_v = 3'b000;
        ad_a[0] = 14'h3FFF; ad_a[1] = 14'h0020; ad_a[2] = 14'h0021;
        push(0, 1'b1, 32'hCAFEF00D);
        push(1, 1'b1, 32'h11111111);
        push(2, 1'b1, 32'h22222222);
        v = 3'b111;
        exp_g[0] = 0;
        exp_g[1] = 1;
        exp_g[2] = 2;
        run_grants(3, 1'b0);
        v = 3'b000;
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main_ram_arbiter.md
Name: main_ram_arbiter

Overview:
- Shares the single-port 16K x 32 work RAM (`MainRAM`) between NUM_REQ requesters: CPU, DMA and debug/loader.
- Round-robin arbitration with a valid/ready request handshake and a registered response pulse.
- Sub-word writes are done as read-modify-write, because the RAM's byte-enable path is not used.
- Sits between the bus interconnect and `MainRAM`; it is the only block that drives the RAM port.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = CPU.
- ADDR_W, 14, word address width (16384 words).
- DATA_W, 32, data width; byte lanes = DATA_W/8.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_be  in  NUM_REQ*4  byte-lane mask per requester; bit 0 = bits 7:0.
- req_addr  in  NUM_REQ*ADDR_W  word address per requester.
- req_wdata  in  NUM_REQ*DATA_W  write data per requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse (read data valid or write done).
- rsp_rdata  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid.
- ram_address  out  ADDR_W  to RAM address.
- ram_wren  out  1  to RAM write enable.
- ram_data  out  DATA_W  to RAM write data.
- ram_q  in  DATA_W  RAM read data; combinational from ram_address.
- busy  out  1  high while in RMW state or while rsp_valid is pending.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_wren=0, ram_address=0, ram_data=0, busy=0.
- Reset during RMW aborts the operation: no RAM write, no rsp_valid.
- States: IDLE, RMW.
- Arbitration (IDLE only):
  - Winner = first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; no valid request -> req_ready=0, ram_wren=0.
  - On acceptance, rr_ptr <= (winner+1) mod NUM_REQ.
- Requester obligations: once asserted, req_valid and its payload are held until ready; no new request before the prior rsp_valid.
- Accept-cycle actions in IDLE (ram_address = winner's address combinationally):
  - Read: rsp_rdata <= ram_q; rsp_valid[winner] pulses the next cycle. Latency 1.
  - Write, be=1111: ram_wren=1, ram_data=wdata this cycle; rsp_valid pulses the next cycle. Latency 1.
  - Write, be=0000: no RAM write; ack the next cycle.
  - Write, partial be: merge_q <= (ram_q & ~mask) | (wdata & mask), with mask expanded per byte; latch addr_q and owner; go to RMW.
- RMW state:
  - ram_address=addr_q, ram_data=merge_q, ram_wren=1, req_ready all 0.
  - Next state IDLE; rsp_valid[owner] pulses the following cycle. Latency 2.
- Throughput: 1 access per cycle, except partial writes, which take 2 cycles.
  - A new grant may be issued in the same cycle an rsp_valid pulse is output.
- ram_address/ram_data in IDLE with no grant hold their last values; ram_wren=0.
- rsp_rdata holds its value until the next read completes; writes leave it unchanged.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,0,...
  - Wait before grant is at most NUM_REQ-1 accepted accesses, each up to 2 cycles.

Decomposition:
- Package main_ram_pkg holds:
  - ADDR_W, DATA_W, NUM_BYTES localparams;
  - state enum {IDLE, RMW};
  - function be_to_mask(be) returning a DATA_W bit mask.
- One sub-module, rr_arbiter: rr_ptr register, request vector in, one-hot grant out, plus an advance input.

Test Plan:
- Reset release with no requests -> all outputs 0; ram_wren never asserted over 20 cycles.
- Req1 full write addr 0x0010, data 0xDEADBEEF, be=1111 -> ram_wren=1 in the accept cycle, rsp_valid[1] 1 cycle later.
  - Req0 read 0x0010 -> rsp_rdata=0xDEADBEEF on the rsp_valid[0] pulse.
- Partial write to 0x0010, be=0010, wdata=0x0000AA00 -> 2 cycles, ram_wren only in RMW.
  - Readback = 0xDEADAAEF.
- All three requesters valid continuously with reads -> grant order 0,1,2,0,1,2.
  - One rsp_valid per cycle, each matching its requester.
- Req2 partial write while req0 and req1 are valid -> req_ready all 0 during RMW.
  - Next grants go to 0 then 1; the RMW result is not corrupted.
- reset_n asserted in RMW cycle (be=0001 to 0x3FFF) -> word at 0x3FFF unchanged, no rsp_valid.
  - After release, rr_ptr=0.
